// File: rtl/dds_pkg.sv
// Shared constants and types for the DDS coefficient table path.
package dds_pkg;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned COEF_W = 48;
    localparam logic [7:0]  HDR    = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_H,
        ST_ADDR_L,
        ST_CNT_H,
        ST_CNT_L,
        ST_DATA,
        ST_CSUM
    } loader_state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_COUNT = 2'd1;
    localparam logic [1:0] ERR_CSUM  = 2'd2;

endpackage

// File: rtl/coef_table_loader.sv
// Parses framed host byte streams and writes 48-bit sin/cos words into the
// coefficient RAM, reporting done or err per frame.
module coef_table_loader #(
    parameter int unsigned ADDR_W = dds_pkg::ADDR_W,
    parameter int unsigned COEF_W = dds_pkg::COEF_W,
    parameter logic [7:0]  HDR    = dds_pkg::HDR
) (
    input  logic              Fg_CLK,
    input  logic              RESET,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              abort,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [COEF_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);
    import dds_pkg::*;

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    loader_state_t     state, state_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [7:0]        cnt_hi, cnt_hi_n;
    logic [15:0]       remain, remain_n;
    logic [2:0]        byte_cnt, byte_cnt_n;
    logic [COEF_W-9:0] asm_reg, asm_n;
    logic [7:0]        csum, csum_n;
    logic              wr_en_n, done_n, err_n;
    logic [ADDR_W-1:0] wr_addr_n;
    logic [COEF_W-1:0] wr_data_n;
    logic [1:0]        err_code_n;
    logic [15:0]       word_cnt;
    logic              accept;

    // The write cycle is the only cycle that refuses a byte.
    assign rx_ready = ~wr_en;
    assign busy     = (state != ST_IDLE);
    assign accept   = rx_valid & rx_ready;
    assign word_cnt = {cnt_hi, rx_data};

    always_ff @(posedge Fg_CLK or posedge RESET) begin
        if (RESET) begin
            state    <= ST_IDLE;
            addr     <= '0;
            cnt_hi   <= '0;
            remain   <= '0;
            byte_cnt <= '0;
            asm_reg  <= '0;
            csum     <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            state    <= state_n;
            addr     <= addr_n;
            cnt_hi   <= cnt_hi_n;
            remain   <= remain_n;
            byte_cnt <= byte_cnt_n;
            asm_reg  <= asm_n;
            csum     <= csum_n;
            wr_en    <= wr_en_n;
            wr_addr  <= wr_addr_n;
            wr_data  <= wr_data_n;
            done     <= done_n;
            err      <= err_n;
            err_code <= err_code_n;
        end
    end

    always_comb begin
        state_n    = state;
        addr_n     = addr;
        cnt_hi_n   = cnt_hi;
        remain_n   = remain;
        byte_cnt_n = byte_cnt;
        asm_n      = asm_reg;
        csum_n     = csum;
        wr_en_n    = 1'b0;
        wr_addr_n  = wr_addr;
        wr_data_n  = wr_data;
        done_n     = 1'b0;
        err_n      = 1'b0;
        err_code_n = err_code;

        if (abort) begin
            state_n    = ST_IDLE;
            remain_n   = '0;
            byte_cnt_n = '0;
            csum_n     = '0;
        end else if (accept) begin
            case (state)
                ST_IDLE: begin
                    csum_n = '0;
                    if (rx_data == HDR) state_n = ST_ADDR_H;
                end
                ST_ADDR_H: begin
                    addr_n  = {rx_data[ADDR_W-9:0], addr[7:0]};
                    csum_n  = csum ^ rx_data;
                    state_n = ST_ADDR_L;
                end
                ST_ADDR_L: begin
                    addr_n[7:0] = rx_data;
                    csum_n      = csum ^ rx_data;
                    state_n     = ST_CNT_H;
                end
                ST_CNT_H: begin
                    cnt_hi_n = rx_data;
                    csum_n   = csum ^ rx_data;
                    state_n  = ST_CNT_L;
                end
                ST_CNT_L: begin
                    csum_n = csum ^ rx_data;
                    if (word_cnt == '0 || {1'b0, word_cnt} > MAX_WORDS) begin
                        err_n      = 1'b1;
                        err_code_n = ERR_COUNT;
                        state_n    = ST_IDLE;
                    end else begin
                        remain_n   = word_cnt;
                        byte_cnt_n = '0;
                        state_n    = ST_DATA;
                    end
                end
                ST_DATA: begin
                    csum_n = csum ^ rx_data;
                    if (byte_cnt == 3'd5) begin
                        wr_en_n    = 1'b1;
                        wr_addr_n  = addr;
                        wr_data_n  = {asm_reg, rx_data};
                        addr_n     = addr + 1'b1;
                        byte_cnt_n = '0;
                        remain_n   = remain - 16'd1;
                        if (remain == 16'd1) state_n = ST_CSUM;
                    end else begin
                        asm_n      = {asm_reg[COEF_W-17:0], rx_data};
                        byte_cnt_n = byte_cnt + 3'd1;
                    end
                end
                ST_CSUM: begin
                    if (rx_data == csum) begin
                        done_n = 1'b1;
                    end else begin
                        err_n      = 1'b1;
                        err_code_n = ERR_CSUM;
                    end
                    state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coef_table_loader.sv
// Self-checking bench for coef_table_loader: table-driven frames, hand-written
// abort/reset sequences and randomized frames against a frame-level model.
module tb_coef_table_loader;
    import dds_pkg::*;

    logic        Fg_CLK = 1'b0;
    logic        RESET;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        abort;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [47:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    coef_table_loader #(.ADDR_W(11), .COEF_W(48), .HDR(8'hA5)) dut (
        .Fg_CLK(Fg_CLK), .RESET(RESET), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .abort(abort), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    always #5 Fg_CLK = ~Fg_CLK;

    typedef struct packed { logic [10:0] a; logic [47:0] d; } wr_t;
    typedef struct {
        logic [10:0] addr; logic [15:0] n; logic [7:0] cx; int garbage; bit cont;
        int e_done; int e_err; logic [1:0] e_code;
    } vec_t;

    int tests = 0, failed = 0, cyc = 0;
    int got_done, got_err, ready_bad, busy_bad, m_done, m_err;
    logic [1:0] model_code = ERR_NONE;
    wr_t  got_wr[$], exp_wr[$];
    int   got_wr_cyc[$], got_ev_cyc[$], acc_wr_cyc[$], acc_dec_cyc[$];
    logic [7:0] fb[$];
    bit   fb_wr[$], fb_dec[$], fb_hdr[$];
    vec_t tbl[9];

    always @(posedge Fg_CLK) cyc <= cyc + 1;

    always @(negedge Fg_CLK) if (!RESET) begin
        if (wr_en) begin got_wr.push_back({wr_addr, wr_data}); got_wr_cyc.push_back(cyc); end
        if (done || err) begin got_ev_cyc.push_back(cyc); if (busy) busy_bad++; end
        if (done) got_done++;
        if (err) got_err++;
        if (rx_ready == wr_en) ready_bad++;
    end

    function automatic void chk(input string nm, input logic [79:0] got, input logic [79:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endfunction

    function automatic void clear_mon();
        got_wr.delete(); got_wr_cyc.delete(); got_ev_cyc.delete();
        acc_wr_cyc.delete(); acc_dec_cyc.delete();
        got_done = 0; got_err = 0; ready_bad = 0; busy_bad = 0;
    endfunction

    function automatic void push(input logic [7:0] b, input bit w, input bit d, input bit h);
        fb.push_back(b); fb_wr.push_back(w); fb_dec.push_back(d); fb_hdr.push_back(h);
    endfunction

    // Leaves rx_valid high so consecutive calls form a continuous stream.
    task automatic send_byte(input logic [7:0] b);
        int unsigned guard = 0;
        rx_data = b; rx_valid = 1'b1;
        while (!rx_ready && guard < 8) begin @(posedge Fg_CLK); #1; guard++; end
        if (!rx_ready) chk("rx_ready_wait", rx_ready, 1);
        @(posedge Fg_CLK); #1;
    endtask

    // Frame-level reference: expected writes, outcome and err_code from the frame's fields.
    task automatic build_frame(input logic [10:0] start, input logic [15:0] n,
                               input logic [7:0] cx, input int garbage);
        logic [7:0] cs, b;
        logic [47:0] w;
        for (int g = 0; g < garbage; g++) push((g % 2) ? 8'hFF : 8'h00, 0, 0, 0);
        push(8'hA5, 0, 0, 1);
        b = {5'($urandom), start[10:8]}; cs = b;  push(b, 0, 0, 0);
        b = start[7:0];                  cs ^= b; push(b, 0, 0, 0);
        b = n[15:8];                     cs ^= b; push(b, 0, 0, 0);
        b = n[7:0];                      cs ^= b;
        if (n == 0 || n > 16'd2048) begin
            push(b, 0, 1, 0);
            m_err++; model_code = ERR_COUNT;
            return;
        end
        push(b, 0, 0, 0);
        for (int unsigned i = 0; i < n; i++) begin
            w = {16'($urandom), 32'($urandom)};
            for (int j = 5; j >= 0; j--) begin
                b = w[j*8 +: 8]; cs ^= b; push(b, j == 0, 0, 0);
            end
            exp_wr.push_back('{a: start + 11'(i), d: w});
        end
        push(cs ^ cx, 0, 1, 0);
        if (cx == 0) m_done++;
        else begin m_err++; model_code = ERR_CSUM; end
    endtask

    task automatic run_frame(input string nm, input bit cont, input int e_done,
                             input int e_err, input logic [1:0] e_code);
        clear_mon();
        for (int k = 0; k < fb.size(); k++) begin
            if (!cont && $urandom_range(0, 2) == 0) begin rx_valid = 0; @(posedge Fg_CLK); #1; end
            send_byte(fb[k]);
            if (fb_wr[k])  acc_wr_cyc.push_back(cyc);
            if (fb_dec[k]) acc_dec_cyc.push_back(cyc);
            if (fb_hdr[k]) chk({nm, ":busy_after_hdr"}, busy, 1);
        end
        rx_valid = 0;
        repeat (4) @(posedge Fg_CLK);
        #1;
        chk({nm, ":wr_count"}, got_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
            chk({nm, ":wr_word"}, 80'(got_wr[i]), 80'(exp_wr[i]));
            chk({nm, ":wr_cycle"}, got_wr_cyc[i], acc_wr_cyc[i]);
        end
        chk({nm, ":done_count"}, got_done, e_done);
        chk({nm, ":err_count"}, got_err, e_err);
        chk({nm, ":err_code"}, err_code, e_code);
        chk({nm, ":event_count"}, got_ev_cyc.size(), acc_dec_cyc.size());
        for (int i = 0; i < acc_dec_cyc.size() && i < got_ev_cyc.size(); i++)
            chk({nm, ":event_cycle"}, got_ev_cyc[i], acc_dec_cyc[i]);
        chk({nm, ":busy_idle"}, busy, 0);
        chk({nm, ":busy_at_pulse"}, busy_bad, 0);
        chk({nm, ":rx_ready_rule"}, ready_bad, 0);
        fb.delete(); fb_wr.delete(); fb_dec.delete(); fb_hdr.delete(); exp_wr.delete();
    endtask

    initial begin
        logic [15:0] n;
        logic [7:0]  cx;
        int nf, sel;

        RESET = 1; rx_valid = 0; rx_data = 0; abort = 0;
        repeat (3) @(posedge Fg_CLK);
        #1;
        chk("reset_outputs", {rx_ready, wr_en, wr_addr, wr_data, busy, done, err, err_code},
            80'({1'b1, 65'd0}));
        RESET = 0;
        @(posedge Fg_CLK); #1;

        // Single word at 0x010; checksum of ADDR_H..last data byte is 0x66.
        push(8'hA5, 0, 0, 1);
        push(8'h00, 0, 0, 0); push(8'h10, 0, 0, 0); push(8'h00, 0, 0, 0); push(8'h01, 0, 0, 0);
        push(8'h11, 0, 0, 0); push(8'h22, 0, 0, 0); push(8'h33, 0, 0, 0);
        push(8'h44, 0, 0, 0); push(8'h55, 0, 0, 0); push(8'h66, 1, 0, 0);
        push(8'h66, 0, 1, 0);
        exp_wr.push_back('{a: 11'h010, d: 48'h112233445566});
        run_frame("plan_single", 1, 1, 0, ERR_NONE);

        push(8'hA5, 0, 0, 1);
        push(8'h00, 0, 0, 0); push(8'h10, 0, 0, 0); push(8'h00, 0, 0, 0); push(8'h01, 0, 0, 0);
        push(8'h11, 0, 0, 0); push(8'h22, 0, 0, 0); push(8'h33, 0, 0, 0);
        push(8'h44, 0, 0, 0); push(8'h55, 0, 0, 0); push(8'h66, 1, 0, 0);
        push(8'h67, 0, 1, 0);
        exp_wr.push_back('{a: 11'h010, d: 48'h112233445566});
        run_frame("plan_badcsum", 1, 0, 1, ERR_CSUM);
        model_code = ERR_CSUM;

        tbl[0] = '{11'h010, 16'd1,      8'h00, 0, 1'b1, 1, 0, 2'd2};
        tbl[1] = '{11'h7FF, 16'd2,      8'h00, 0, 1'b0, 1, 0, 2'd2};
        tbl[2] = '{11'h123, 16'd0,      8'h00, 0, 1'b1, 0, 1, 2'd1};
        tbl[3] = '{11'h123, 16'h0801,   8'h00, 0, 1'b1, 0, 1, 2'd1};
        tbl[4] = '{11'h200, 16'd1,      8'h00, 0, 1'b0, 1, 0, 2'd1};
        tbl[5] = '{11'h055, 16'd1,      8'h01, 0, 1'b1, 0, 1, 2'd2};
        tbl[6] = '{11'h100, 16'd3,      8'h00, 2, 1'b1, 1, 0, 2'd2};
        tbl[7] = '{11'h400, 16'h0800,   8'h00, 0, 1'b1, 1, 0, 2'd2};
        tbl[8] = '{11'h7FE, 16'hFFFF,   8'h00, 0, 1'b0, 0, 1, 2'd1};
        for (int t = 0; t < 9; t++) begin
            build_frame(tbl[t].addr, tbl[t].n, tbl[t].cx, tbl[t].garbage);
            run_frame($sformatf("tbl%0d", t), tbl[t].cont, tbl[t].e_done, tbl[t].e_err, tbl[t].e_code);
        end

        // Abort alongside the 4th data byte: abort wins, nothing is written.
        clear_mon();
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        rx_data = 8'h44; abort = 1;
        @(posedge Fg_CLK); #1;
        abort = 0; rx_valid = 0;
        chk("abort:busy_next", busy, 0);
        repeat (3) @(posedge Fg_CLK);
        #1;
        chk("abort:no_write", got_wr.size(), 0);
        chk("abort:no_err", got_err, 0);
        chk("abort:no_done", got_done, 0);
        chk("abort:err_code", err_code, model_code);
        m_done = 0; m_err = 0;
        build_frame(11'h300, 16'd2, 8'h00, 0);
        run_frame("after_abort", 1, m_done, m_err, model_code);

        // Reset during the write cycle drops the write.
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h23); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
        rx_data = 8'h66;
        @(posedge Fg_CLK); #1;
        rx_valid = 0;
        chk("rst:wr_en_before", wr_en, 1);
        RESET = 1; #1;
        chk("rst:outputs", {rx_ready, wr_en, wr_addr, wr_data, busy, done, err, err_code},
            80'({1'b1, 65'd0}));
        @(negedge Fg_CLK);
        RESET = 0;
        model_code = ERR_NONE;
        @(posedge Fg_CLK); #1;

        for (int r = 0; r < 16; r++) begin
            m_done = 0; m_err = 0;
            nf = $urandom_range(1, 2);
            for (int f = 0; f < nf; f++) begin
                sel = $urandom_range(0, 9);
                n = (sel == 0) ? 16'd0 : (sel == 1) ? 16'($urandom_range(2049, 65535))
                                                    : 16'($urandom_range(1, 4));
                cx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
                build_frame(11'($urandom), n, cx, $urandom_range(0, 2));
            end
            run_frame($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), m_done, m_err, model_code);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
